// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-128 round controller: counter codes, FSM states, code decoder.
package aes_ctrl_pkg;

    // State_Counter LFSR sequence, one code per (round, phase) step.
    localparam logic [4:0] C_00 = 5'd1;
    localparam logic [4:0] C_01 = 5'd3;
    localparam logic [4:0] C_02 = 5'd7;
    localparam logic [4:0] C_03 = 5'd15;
    localparam logic [4:0] C_04 = 5'd31;
    localparam logic [4:0] C_05 = 5'd30;
    localparam logic [4:0] C_06 = 5'd29;
    localparam logic [4:0] C_07 = 5'd26;
    localparam logic [4:0] C_08 = 5'd21;
    localparam logic [4:0] C_09 = 5'd10;
    localparam logic [4:0] C_10 = 5'd20;
    localparam logic [4:0] C_11 = 5'd9;
    localparam logic [4:0] C_12 = 5'd19;
    localparam logic [4:0] C_13 = 5'd6;
    localparam logic [4:0] C_14 = 5'd12;
    localparam logic [4:0] C_15 = 5'd24;
    localparam logic [4:0] C_16 = 5'd17;
    localparam logic [4:0] C_17 = 5'd2;
    localparam logic [4:0] C_18 = 5'd4;
    localparam logic [4:0] C_19 = 5'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } lfsr_dec_t;

    // Map an LFSR code to its step index; codes outside the sequence give idx 0, valid 0.
    function automatic lfsr_dec_t lfsr_code_to_idx(input logic [4:0] code);
        lfsr_dec_t dec;
        dec.valid = 1'b1;
        dec.idx   = 5'd0;
        case (code)
            C_00:    dec.idx = 5'd0;
            C_01:    dec.idx = 5'd1;
            C_02:    dec.idx = 5'd2;
            C_03:    dec.idx = 5'd3;
            C_04:    dec.idx = 5'd4;
            C_05:    dec.idx = 5'd5;
            C_06:    dec.idx = 5'd6;
            C_07:    dec.idx = 5'd7;
            C_08:    dec.idx = 5'd8;
            C_09:    dec.idx = 5'd9;
            C_10:    dec.idx = 5'd10;
            C_11:    dec.idx = 5'd11;
            C_12:    dec.idx = 5'd12;
            C_13:    dec.idx = 5'd13;
            C_14:    dec.idx = 5'd14;
            C_15:    dec.idx = 5'd15;
            C_16:    dec.idx = 5'd16;
            C_17:    dec.idx = 5'd17;
            C_18:    dec.idx = 5'd18;
            C_19:    dec.idx = 5'd19;
            default: dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/aes_lfsr_decode.sv
// Combinational LFSR code decoder, shared with the key-schedule block.
module aes_lfsr_decode
    import aes_ctrl_pkg::*;
(
    input  logic [4:0] state_counter,
    output logic [4:0] idx,
    output logic       valid
);

    lfsr_dec_t dec;

    // Translate the counter code into step index plus legality flag.
    always_comb begin
        dec   = lfsr_code_to_idx(state_counter);
        idx   = dec.idx;
        valid = dec.valid;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Per-block AES-128 round sequencer: accepts a block, steps State_Counter through 20 codes,
// decodes round/phase enables and hands the finished block downstream.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter bit          ERR_CHECK  = 1'b1,
    // Must stay 10: two phases per round have to fill the 20-code counter cycle.
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_en,
    input  logic       abort,
    input  logic [4:0] state_counter,
    output logic       en_signal,
    output logic [3:0] round_idx,
    output logic       sub_shift_en,
    output logic       key_step_en,
    output logic       mix_en,
    output logic       add_key_en,
    output logic       last_round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);

    localparam logic [3:0] LastRoundIdx = 4'(NUM_ROUNDS - 1);
    localparam logic [4:0] LastStep     = 5'(2 * NUM_ROUNDS - 1);

    ctrl_state_t state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d;
    logic [4:0]  code_idx;
    logic        code_valid;

    aes_lfsr_decode u_decode (
        .state_counter (state_counter),
        .idx           (code_idx),
        .valid         (code_valid)
    );

    // Next-state logic and all combinational outputs.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        err_d        = err_q;
        in_ready     = 1'b0;
        load_en      = 1'b0;
        en_signal    = 1'b0;
        round_idx    = 4'd0;
        sub_shift_en = 1'b0;
        key_step_en  = 1'b0;
        mix_en       = 1'b0;
        add_key_en   = 1'b0;
        last_round   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort outranks a pending block
                in_ready = !abort;
                load_en  = in_valid && !abort;
                if (load_en) begin
                    state_d = RUN;
                    err_d   = 1'b0;
                end
            end

            RUN: begin
                en_signal = 1'b1;
                if (!code_valid && ERR_CHECK) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Illegal codes decode as step 0 when checking is disabled.
                    round_idx    = code_idx[4:1];
                    sub_shift_en = !code_idx[0];
                    key_step_en  = !code_idx[0];
                    add_key_en   = code_idx[0];
                    last_round   = (round_idx == LastRoundIdx);
                    mix_en       = code_idx[0] && !last_round;
                    if (code_valid && (code_idx == LastStep)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end

            DONE: begin
                if (abort || out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule
